tt_um_uart_rx_d: RTL and testbench

Tiny Tapeout user project that receives 8N1 asynchronous serial bytes on a dedicated input pin and presents each byte on the dedicated outputs. It optionally inverts the byte, so it pairs with the team's existing inverter project. A one-cycle strobe, a sticky framing-error flag and a busy flag are driven on the bidirectional pins. It is the receiving end for the serial streams the team's other projects and the test host transmit into the tile.

---
 rtl/tt_um_uart_rx_d_pkg.sv | 19 +
 rtl/tt_um_uart_rx_d_if.sv | 10 +
 rtl/tt_um_uart_rx_d_core.sv | 122 ++++++++++++
 rtl/tt_um_uart_rx_d.sv | 43 ++++
 tb/tb_tt_um_uart_rx_d.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/tt_um_uart_rx_d_pkg.sv
// rtl/tt_um_uart_rx_d_pkg.sv - shared types and pin map for the UART receiver tile
package tt_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int RX_PIN    = 3;
    localparam int INV_PIN   = 0;
    localparam int VALID_BIT = 0;
    localparam int FERR_BIT  = 1;
    localparam int BUSY_BIT  = 2;

    localparam logic [7:0] UIO_OE_MASK = 8'h07;

endpackage

// File: rtl/tt_um_uart_rx_d_if.sv
// rtl/tt_um_uart_rx_d_if.sv - received-byte bundle from the receiver core
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output data, output valid, output frame_err, output busy);
    modport slave  (input  data, input  valid, input  frame_err, input  busy);
endinterface

// File: rtl/tt_um_uart_rx_d_core.sv
// rtl/tt_um_uart_rx_d_core.sv - 8N1 receiver: synchronizer, mid-bit sampling FSM, byte register
module uart_rx_core
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx_i,
    uart_rx_if.master rx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e       state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic            rxs_d_q, rxs_d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rxs;

    assign rxs = sync_q[1];

    // Line idles high, so the synchronizer and edge detector reset to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sync_q    <= 2'b11;
            rxs_d_q   <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            rxs_d_q   <= rxs_d_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[0], rx_i};
        rxs_d_d   = rxs;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = ferr_q;

        case (state_q)
            ST_IDLE: begin
                if (rxs_d_q && !rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    if (!rxs) begin
                        state_d   = ST_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = 1'b0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_o.data      = data_q;
    assign rx_o.valid     = valid_q;
    assign rx_o.frame_err = ferr_q;
    assign rx_o.busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/tt_um_uart_rx_d.sv
// rtl/tt_um_uart_rx_d.sv - Tiny Tapeout pin wrapper around the UART receiver core
module tt_um_uart_rx_d
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    uart_rx_if rx_bus ();

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .rx_i (ui_in[RX_PIN]),
        .rx_o (rx_bus.master)
    );

    // Inversion is deliberately combinational so the pin toggles the output in the same cycle.
    assign uo_out = ui_in[INV_PIN] ? ~rx_bus.data : rx_bus.data;

    always_comb begin
        uio_out            = 8'h00;
        uio_out[VALID_BIT] = rx_bus.valid;
        uio_out[FERR_BIT]  = rx_bus.frame_err;
        uio_out[BUSY_BIT]  = rx_bus.busy;
    end

    assign uio_oe = UIO_OE_MASK;

    logic unused_pins;
    assign unused_pins = &{1'b0, ena, uio_in, ui_in[7:4], ui_in[2:1]};

endmodule

// File: tb/tb_tt_um_uart_rx_d.sv
// tb/tb_tt_um_uart_rx_d.sv - directed self-checking bench for tt_um_uart_rx_d
module tb_tt_um_uart_rx_d;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       inv = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int bcount = 0;
    logic [7:0] cap[$];

    always #5 clk = ~clk;

    assign ui_in = {4'b0000, rx, 2'b00, inv};

    tt_um_uart_rx_d #(.CLKS_PER_BIT(CPB)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (1'b1),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    uart_rx_if mon ();
    assign mon.data      = uo_out;
    assign mon.valid     = uio_out[0];
    assign mon.frame_err = uio_out[1];
    assign mon.busy      = uio_out[2];

    always @(negedge clk) begin
        if (rst_n) begin
            if (mon.valid) begin
                vcount++;
                cap.push_back(mon.data);
            end
            if (mon.busy) bcount++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    int v0;
    int b0;

    initial begin
        // Reset with line idle
        idle(5);
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h07);
        rst_n = 1'b1;
        b0 = bcount;
        idle(100);
        check("idle_busy_cycles", bcount - b0, 0);

        // Good frame 0xA5
        v0 = vcount;
        b0 = bcount;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_valid_pulses", vcount - v0, 1);
        check("a5_captured", cap[cap.size()-1], 8'hA5);
        check("a5_uo", uo_out, 8'hA5);
        check("a5_ferr", uio_out[1], 1'b0);
        check("a5_busy_cycles", bcount - b0, 152);
        check("a5_busy_after", uio_out[2], 1'b0);

        // Framing error on 0x55
        v0 = vcount;
        send_frame(8'h55, 1'b0);
        idle(20);
        check("ferr_set", uio_out[1], 1'b1);
        check("ferr_uo_hold", uo_out, 8'hA5);
        check("ferr_no_valid", vcount - v0, 0);

        // Start-bit glitch
        v0 = vcount;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        check("glitch_no_valid", vcount - v0, 0);
        check("glitch_uo_hold", uo_out, 8'hA5);
        check("glitch_ferr_hold", uio_out[1], 1'b1);
        check("glitch_busy", uio_out[2], 1'b0);

        // Good 0x0F clears the sticky error
        v0 = vcount;
        send_frame(8'h0F, 1'b1);
        idle(20);
        check("0f_valid_pulses", vcount - v0, 1);
        check("0f_uo", uo_out, 8'h0F);
        check("0f_ferr_clr", uio_out[1], 1'b0);

        // Inverted, back-to-back frames
        inv = 1'b1;
        v0 = vcount;
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("b2b_valid_pulses", vcount - v0, 2);
        if (vcount - v0 == 2) begin
            check("b2b_first", cap[cap.size()-2], 8'hC3);
            check("b2b_second", cap[cap.size()-1], 8'h7E);
        end
        check("inv_uo", uo_out, 8'h7E);
        inv = 1'b0;
        #1;
        check("inv_off_same_cycle", uo_out, 8'h81);

        // Reset during data bit 4 of 0xFF
        v0 = vcount;
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(4 * CPB + CPB / 2);
        check("midframe_busy", uio_out[2], 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_uo", uo_out, 8'h00);
        check("midrst_uio_out", uio_out, 8'h00);
        check("midrst_uio_oe", uio_oe, 8'h07);
        idle(3);
        rst_n = 1'b1;
        idle(6 * CPB);
        check("midrst_no_valid", vcount - v0, 0);
        check("midrst_busy", uio_out[2], 1'b0);

        send_frame(8'h42, 1'b1);
        idle(20);
        check("42_valid_pulses", vcount - v0, 1);
        check("42_uo", uo_out, 8'h42);
        check("42_ferr", uio_out[1], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
